// File: rtl/uart_frame_rx.sv
// Frame parser behind the uart rx FIFO: hunts SYNC, collects TYPE/LEN/payload/CHK and
// hands checked frames to the consumer over valid/ready; bad or stalled frames raise err_pulse.
module uart_frame_rx #(
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         MAX_LEN = 4,
  parameter int         TIMEOUT = 750000,
  parameter int         TO_BIT  = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_empty,
  input  logic [7:0]             r_data,
  output logic                   rd_uart,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic [7:0]             frame_type,
  output logic [3:0]             frame_len,
  output logic [8*MAX_LEN-1:0]   frame_data,
  output logic                   err_pulse,
  output logic [1:0]             err_code
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TYPE = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_PAY  = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;
  localparam logic [2:0] S_HOLD = 3'd5;

  localparam int         TO_LAST   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  logic [2:0]           state;
  logic                 en;
  logic [7:0]           type_q;
  logic [7:0]           chk;
  logic [3:0]           len_q;
  logic [3:0]           idx;
  logic [8*MAX_LEN-1:0] pay_buf;
  logic [TO_BIT-1:0]    to_cnt;
  logic                 accept;
  logic                 active;
  logic                 to_hit;

  // Popping and sampling share one condition, so every popped byte is seen exactly once.
  assign accept      = en & ~rx_empty & (state != S_HOLD);
  assign rd_uart     = accept;
  assign frame_valid = (state == S_HOLD);
  assign active      = (state == S_TYPE) | (state == S_LEN) | (state == S_PAY) | (state == S_CHK);
  assign to_hit      = (TIMEOUT != 0) & active & ~accept & (to_cnt == TO_BIT'(TO_LAST));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en <= 1'b0;
    end else begin
      en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (!active || accept || to_hit) begin
      to_cnt <= '0;
    end else if (TIMEOUT != 0) begin
      to_cnt <= to_cnt + TO_BIT'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      type_q     <= '0;
      chk        <= '0;
      len_q      <= '0;
      idx        <= '0;
      pay_buf    <= '0;
      frame_type <= '0;
      frame_len  <= '0;
      frame_data <= '0;
      err_pulse  <= 1'b0;
      err_code   <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (to_hit) begin
        state     <= S_IDLE;
        err_pulse <= 1'b1;
        err_code  <= 2'd3;
      end else if (state == S_HOLD) begin
        if (frame_ready) begin
          state <= S_IDLE;
        end
      end else if (accept) begin
        case (state)
          S_IDLE: begin
            if (r_data == SYNC) begin
              state <= S_TYPE;
            end
          end
          S_TYPE: begin
            type_q <= r_data;
            chk    <= r_data;
            state  <= S_LEN;
          end
          S_LEN: begin
            if (r_data > MAX_LEN_B) begin
              err_pulse <= 1'b1;
              err_code  <= 2'd2;
              state     <= S_IDLE;
            end else begin
              // Clearing here guarantees unused payload bytes read as zero.
              len_q   <= r_data[3:0];
              chk     <= chk ^ r_data;
              idx     <= '0;
              pay_buf <= '0;
              state   <= (r_data == 8'd0) ? S_CHK : S_PAY;
            end
          end
          S_PAY: begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (idx == 4'(i)) begin
                pay_buf[8*i +: 8] <= r_data;
              end
            end
            chk <= chk ^ r_data;
            idx <= idx + 4'd1;
            if (idx == len_q - 4'd1) begin
              state <= S_CHK;
            end
          end
          S_CHK: begin
            if (r_data == chk) begin
              frame_type <= type_q;
              frame_len  <= len_q;
              frame_data <= pay_buf;
              state      <= S_HOLD;
            end else begin
              err_pulse <= 1'b1;
              err_code  <= 2'd1;
              state     <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: directed frames from the block's test list plus a randomized byte
// stream scored against a positional frame-scanning reference model.
module tb_uart_frame_rx;

  localparam int         MAX_LEN = 4;
  localparam int         TIMEOUT = 16;
  localparam logic [7:0] SYNC    = 8'hA5;

  typedef logic [63:0] ev_t;
  typedef ev_t         ev_q_t[$];
  typedef logic [7:0]  byte_q_t[$];

  logic         clk = 1'b0;
  logic         reset;
  logic         rx_empty = 1'b1;
  logic [7:0]   r_data = 8'h00;
  logic         rd_uart;
  logic         frame_valid;
  logic         frame_ready;
  logic [7:0]   frame_type;
  logic [3:0]   frame_len;
  logic [31:0]  frame_data;
  logic         err_pulse;
  logic [1:0]   err_code;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] fifo[$];
  ev_t        obs_ev[$];

  uart_frame_rx #(
    .SYNC(SYNC), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT), .TO_BIT(8)
  ) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_type(frame_type),
    .frame_len(frame_len), .frame_data(frame_data), .err_pulse(err_pulse), .err_code(err_code)
  );

  always #5 clk = ~clk;

  function automatic ev_t make_frame(input logic [7:0] t, input logic [3:0] l, input logic [31:0] d);
    return {2'b01, 2'b00, t, l, 16'h0000, d};
  endfunction

  function automatic ev_t make_err(input logic [1:0] c);
    return {2'b10, c, 60'h0};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] bytes, input int n);
    @(posedge clk);
    for (int k = 0; k < n; k++) fifo.push_back(bytes[8*(n-1-k) +: 8]);
  endtask

  task automatic waitDone(input int n_ev);
    int c;
    c = 0;
    while (c < 3000 && !(fifo.size() == 0 && obs_ev.size() >= n_ev)) begin
      @(negedge clk);
      c++;
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic compareEvents(input string tag, input ev_q_t exp);
    checkOutput({tag, "_count"}, 64'(obs_ev.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < obs_ev.size(); i++)
      checkOutput($sformatf("%s_ev%0d", tag, i), obs_ev[i], exp[i]);
  endtask

  // Scans the byte stream frame by frame; every pushed byte is eventually consumed.
  function automatic ev_q_t ref_model(input byte_q_t s);
    ev_q_t      ev;
    int         i;
    int         l;
    logic [7:0] x;
    logic [31:0] d;
    ev = {};
    i  = 0;
    while (i < s.size()) begin
      if (s[i] != SYNC) begin
        i++;
        continue;
      end
      if (i + 2 >= s.size()) break;
      l = int'(s[i+2]);
      if (l > MAX_LEN) begin
        ev.push_back(make_err(2'd1 + 2'd1));
        i += 3;
        continue;
      end
      if (i + 3 + l >= s.size()) break;
      x = s[i+1] ^ s[i+2];
      d = '0;
      for (int k = 0; k < l; k++) begin
        x ^= s[i+3+k];
        d[8*k +: 8] = s[i+3+k];
      end
      if (s[i+3+l] == x) ev.push_back(make_frame(s[i+1], 4'(l), d));
      else               ev.push_back(make_err(2'd1));
      i += 4 + l;
    end
    return ev;
  endfunction

  // FIFO model: head presented on the falling edge, popped on the rising edge it is read.
  always @(negedge clk) begin
    rx_empty = (fifo.size() == 0);
    r_data   = (fifo.size() != 0) ? fifo[0] : 8'h00;
  end

  always @(posedge clk) begin
    if (rd_uart && fifo.size() != 0) void'(fifo.pop_front());
  end

  logic        prev_hold = 1'b0;
  logic [43:0] prev_snap = '0;

  always @(negedge clk) begin
    #2;
    if (!reset) begin
      prev_hold = 1'b0;
    end else begin
      checkOutput("valid_err_excl", 64'(frame_valid & err_pulse), 64'd0);
      if (prev_hold) begin
        checkOutput("hold_valid", 64'(frame_valid), 64'd1);
        checkOutput("hold_stable", 64'({frame_type, frame_len, frame_data}), 64'(prev_snap));
      end
      if (frame_valid && frame_ready) obs_ev.push_back(make_frame(frame_type, frame_len, frame_data));
      if (err_pulse) obs_ev.push_back(make_err(err_code));
      prev_hold = frame_valid & ~frame_ready;
      prev_snap = {frame_type, frame_len, frame_data};
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ev_q_t      exp;
    byte_q_t    stream;
    int         kind;
    int         nj;
    int         fl;
    logic [7:0] jb;
    logic [7:0] ft;
    logic [7:0] pb;
    logic [7:0] ck;

    reset       = 1'b0;
    frame_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_outputs",
                64'({rd_uart, frame_valid, err_pulse, err_code, frame_type, frame_len, frame_data}), 64'd0);

    // A byte waiting across release must not be popped in the first cycle out of reset.
    applyStimulus(128'h00, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rd_first_cycle", 64'(rd_uart), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("rd_after_en", 64'(rd_uart), 64'd1);
    repeat (4) @(negedge clk);

    $display("[TB] test 1: single good frame");
    frame_ready = 1'b1;
    obs_ev.delete();
    applyStimulus(128'hA5_01_02_11_22_30, 6);
    waitDone(1);
    exp = {};
    exp.push_back(make_frame(8'h01, 4'd2, 32'h0000_2211));
    compareEvents("t1", exp);

    $display("[TB] test 2: junk then bad checksum");
    obs_ev.delete();
    applyStimulus(128'h00_FF_A5_01_02_11_22_31, 8);
    waitDone(1);
    exp = {};
    exp.push_back(make_err(2'd1));
    compareEvents("t2", exp);

    $display("[TB] test 3: oversize LEN then empty payload");
    obs_ev.delete();
    applyStimulus(128'hA5_07_05_A5_07_00_07, 7);
    waitDone(2);
    exp = {};
    exp.push_back(make_err(2'd2));
    exp.push_back(make_frame(8'h07, 4'd0, 32'h0));
    compareEvents("t3", exp);
    checkOutput("t3_code_held", 64'(err_code), 64'd2);

    $display("[TB] test 4: inter-byte timeout");
    obs_ev.delete();
    applyStimulus(128'hA5_01, 2);
    repeat (10) @(negedge clk);
    #3;
    checkOutput("t4_no_early_to", 64'(obs_ev.size()), 64'd0);
    waitDone(1);
    applyStimulus(128'hA5_03_01_AA_A8, 5);
    waitDone(2);
    exp = {};
    exp.push_back(make_err(2'd3));
    exp.push_back(make_frame(8'h03, 4'd1, 32'h0000_00AA));
    compareEvents("t4", exp);

    $display("[TB] test 5: backpressure with two queued frames");
    obs_ev.delete();
    @(negedge clk);
    #1;
    frame_ready = 1'b0;
    applyStimulus(128'hA5_01_02_11_22_30_A5_07_00_07, 10);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #1;
      if (frame_valid) break;
    end
    checkOutput("t5_valid", 64'(frame_valid), 64'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      checkOutput("t5_no_pop", 64'(rd_uart), 64'd0);
      checkOutput("t5_held", 64'({frame_type, frame_len, frame_data}),
                  64'({8'h01, 4'd2, 32'h0000_2211}));
    end
    frame_ready = 1'b1;
    waitDone(2);
    exp = {};
    exp.push_back(make_frame(8'h01, 4'd2, 32'h0000_2211));
    exp.push_back(make_frame(8'h07, 4'd0, 32'h0));
    compareEvents("t5", exp);

    $display("[TB] test 6: reset in the middle of a payload");
    obs_ev.delete();
    applyStimulus(128'hA5_01_03_11_22, 5);
    repeat (8) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("t6_reset_outputs",
                64'({rd_uart, frame_valid, err_pulse, err_code, frame_type, frame_len, frame_data}), 64'd0);
    repeat (3) @(negedge clk);
    fifo.delete();
    reset = 1'b1;
    repeat (5) @(negedge clk);
    #3;
    checkOutput("t6_no_err", 64'(obs_ev.size()), 64'd0);
    applyStimulus(128'hA5_02_01_5A_59, 5);
    waitDone(1);
    exp = {};
    exp.push_back(make_frame(8'h02, 4'd1, 32'h0000_005A));
    compareEvents("t6", exp);

    $display("[TB] test 7: randomized stream with random ready");
    obs_ev.delete();
    stream = {};
    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 2) == 0) begin
        nj = $urandom_range(1, 3);
        for (int j = 0; j < nj; j++) begin
          jb = 8'($urandom_range(0, 255));
          if (jb == SYNC) jb = 8'h00;
          stream.push_back(jb);
        end
      end
      ft = 8'($urandom_range(0, 255));
      stream.push_back(SYNC);
      stream.push_back(ft);
      if (kind == 0) begin
        stream.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
      end else begin
        fl = $urandom_range(0, MAX_LEN);
        ck = ft ^ 8'(fl);
        stream.push_back(8'(fl));
        for (int j = 0; j < fl; j++) begin
          pb = 8'($urandom_range(0, 255));
          ck ^= pb;
          stream.push_back(pb);
        end
        if (kind == 1) ck ^= 8'($urandom_range(1, 255));
        stream.push_back(ck);
      end
    end
    @(posedge clk);
    foreach (stream[k]) fifo.push_back(stream[k]);
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      #1;
      frame_ready = ($urandom_range(0, 3) != 0);
      if (fifo.size() == 0 && !frame_valid) break;
    end
    @(negedge clk);
    #1;
    frame_ready = 1'b1;
    repeat (20) @(negedge clk);
    exp = ref_model(stream);
    compareEvents("rand", exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
